fixed_round_sat_pipe: RTL and testbench



---
 rtl/fixed_round_pkg.sv | 21 ++
 rtl/fixed_round_core.sv | 40 ++++
 rtl/fixed_round_sat_pipe.sv | 137 +++++++++++++
 tb/tb_fixed_round_sat_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_round_pkg.sv
// Shared types and width helpers for the fixed-point round/saturate pipe.
// Imported by fixed_round_core and fixed_round_sat_pipe.
package fixed_round_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,
    RND_HALF_UP   = 2'b01,
    RND_HALF_EVEN = 2'b10
  } round_mode_t;

  // Integer bits of the fixed-point input.
  function automatic int int_w(input int in_w, input int frac_w);
    return in_w - frac_w;
  endfunction

  // Width of the rounded result; one spare bit absorbs the round-up carry.
  function automatic int rnd_w(input int in_w, input int frac_w);
    return in_w - frac_w + 1;
  endfunction

endpackage

// File: rtl/fixed_round_core.sv
// Combinational rounding of a signed fixed-point sample to a signed integer.
// Output is one bit wider than the integer part, so rounding cannot overflow.
module fixed_round_core
  import fixed_round_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8
) (
  input  logic [IN_W-1:0]        in_data,
  input  logic [1:0]             mode,
  output logic [IN_W-FRAC_W:0]   r
);

  localparam int RW = rnd_w(IN_W, FRAC_W);
  localparam logic [FRAC_W-1:0] HALF =
    FRAC_W'(1) << (FRAC_W - 1);

  logic [RW-1:0]     fl;
  logic [RW-1:0]     hu;
  logic [FRAC_W-1:0] frac;
  logic              tie;

  assign frac = in_data[FRAC_W-1:0];
  assign tie  = (frac == HALF);
  // Floor is the sign-extended integer part.
  assign fl   = {in_data[IN_W-1], in_data[IN_W-1:FRAC_W]};
  // Adding half then flooring equals floor plus the top fraction bit.
  assign hu   = fl + RW'(in_data[FRAC_W-1]);

  // Select the rounded value; the reserved mode falls back to floor.
  always_comb begin
    r = fl;
    unique case (1'b1)
      (mode == RND_HALF_UP):   r = hu;
      (mode == RND_HALF_EVEN): r = (tie && !fl[0]) ? fl : hu;
      default:                 r = fl;
    endcase
  end

endmodule

// File: rtl/fixed_round_sat_pipe.sv
// Two-stage fixed-point to integer converter: round, then saturate.
// Optional saturation counter enabled by FIXED_ROUND_SAT_COUNT_EN.
module fixed_round_sat_pipe
  import fixed_round_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
`ifdef FIXED_ROUND_SAT_COUNT_EN
  ,
  output logic [CNT_W-1:0]  sat_count,
  input  logic              sat_count_clr
`endif
);

  localparam int RW = rnd_w(IN_W, FRAC_W);
  localparam logic [OUT_W-1:0] MAXV =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV =
    {1'b1, {(OUT_W-1){1'b0}}};

  if (FRAC_W < 1 || FRAC_W > IN_W - 1 ||
      OUT_W < 2 || OUT_W > RW || CNT_W < 1)
  begin : g_bad_param
    $error("fixed_round_sat_pipe: illegal parameters");
  end

  logic [RW-1:0]    r;
  logic             s2_adv;
  logic             s1_adv;

  logic             s1_valid_q, s1_valid_d;
  logic [RW-1:0]    s1_r_q, s1_r_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;

  logic [RW-OUT_W:0] hi;
  logic              ovf;
  logic [OUT_W-1:0]  sat_data;

  fixed_round_core #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .in_data (in_data),
    .mode    (in_mode),
    .r       (r)
  );

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Bits above the output sign must all match the sign to fit.
  assign hi       = s1_r_q[RW-1:OUT_W-1];
  assign ovf      = !((&hi) || !(|hi));
  assign sat_data = ovf ? (s1_r_q[RW-1] ? MINV : MAXV)
                        : s1_r_q[OUT_W-1:0];

  // Next state for both stages; each holds unless it can advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_r_d = r;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = sat_data;
        out_sat_d  = ovf;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

`ifdef FIXED_ROUND_SAT_COUNT_EN
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  // Sticky saturation counter; clear has priority over increment.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_count_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q &&
                 !(&sat_count_q)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_fixed_round_sat_pipe.sv
// Directed bench for fixed_round_sat_pipe (default and OUT_W=6 builds).
// Counter checks compile in with FIXED_ROUND_SAT_COUNT_EN.
module tb_fixed_round_sat_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sat;

  logic        in_valid6 = 1'b0;
  logic        in_ready6;
  logic [15:0] in_data6 = '0;
  logic [1:0]  in_mode6 = '0;
  logic        out_valid6;
  logic        out_ready6 = 1'b1;
  logic [5:0]  out_data6;
  logic        out_sat6;

`ifdef FIXED_ROUND_SAT_COUNT_EN
  logic [15:0] sat_count;
  logic        sat_count_clr = 1'b0;
  logic [15:0] sat_count6;
  logic        sat_count_clr6 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixed_round_sat_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef FIXED_ROUND_SAT_COUNT_EN
    ,
    .sat_count     (sat_count),
    .sat_count_clr (sat_count_clr)
`endif
  );

  fixed_round_sat_pipe #(.OUT_W(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .in_data   (in_data6),
    .in_mode   (in_mode6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .out_data  (out_data6),
    .out_sat   (out_sat6)
`ifdef FIXED_ROUND_SAT_COUNT_EN
    ,
    .sat_count     (sat_count6),
    .sat_count_clr (sat_count_clr6)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: valid=%b data=%h sat=%b want 0/00/0",
               out_valid, out_data, out_sat);
    end
    total++;
    if (out_valid6 !== 1'b0 || out_data6 !== 6'h00) begin
      bad++;
      $display("FAIL reset_out6: valid=%b data=%h want 0/00",
               out_valid6, out_data6);
    end
`ifdef FIXED_ROUND_SAT_COUNT_EN
    total++;
    if (sat_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", sat_count);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || in_ready6 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b/%b want 1/1", in_ready, in_ready6);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] din [11];
    logic [1:0]  md  [11];
    logic [7:0]  exd [11];
    logic        exs [11];
    din = '{16'h0280, 16'h0280, 16'h0280, 16'h0380, 16'hFD80, 16'hFD80,
            16'hFD80, 16'h8000, 16'h7F80, 16'h7F7F, 16'h0280};
    md  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01,
            2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    exd = '{8'h02, 8'h03, 8'h02, 8'h04, 8'hFD, 8'hFE,
            8'hFE, 8'h80, 8'h7F, 8'h7F, 8'h02};
    exs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      in_mode  = md[i];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL rnd%0d_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_early: out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== exd[i] || out_sat !== exs[i]) begin
        bad++;
        $display("FAIL rnd%0d_out: in=%h mode=%b got v=%b d=%h s=%b want 1/%h/%b",
                 i, din[i], md[i], out_valid, out_data, out_sat, exd[i], exs[i]);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_drain: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_out_w6();
    logic [15:0] din [3];
    logic [5:0]  exd [3];
    logic        exs [3];
    din = '{16'hDF00, 16'h2000, 16'h1F00};
    exd = '{6'h20, 6'h1F, 6'h1F};
    exs = '{1'b1, 1'b1, 1'b0};
    out_ready6 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid6 = 1'b1;
      in_data6  = din[i];
      in_mode6  = 2'b00;
      @(posedge clk); #1;
      in_valid6 = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid6 !== 1'b1 || out_data6 !== exd[i] || out_sat6 !== exs[i]) begin
        bad++;
        $display("FAIL w6_%0d: in=%h got v=%b d=%h s=%b want 1/%h/%b",
                 i, din[i], out_valid6, out_data6, out_sat6, exd[i], exs[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [8];
    logic [1:0]  md  [8];
    logic [7:0]  exd [8];
    logic        exs [8];
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    int stalls = 0;
    bit m_s1 = 1'b0;
    bit m_out = 1'b0;
    bit s2a, exp_rdy, acc, cons;
    bit prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic prev_s = 1'b0;
    din = '{16'h0100, 16'h0180, 16'h0180, 16'hFF80,
            16'hFF80, 16'h7FFF, 16'h8000, 16'h0A40};
    md  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
    exd = '{8'h01, 8'h02, 8'h02, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h0A};
    exs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    while (rx < 8 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (tx < 8);
      if (tx < 8) begin
        in_data = din[tx];
        in_mode = md[tx];
      end
      #1;
      s2a     = !m_out || out_ready;
      exp_rdy = !m_s1 || s2a;
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      total++;
      if (out_valid !== m_out) begin
        bad++;
        $display("FAIL b2b_valid c%0d: got %b want %b", cyc, out_valid, m_out);
      end
      if (prev_stall) begin
        stalls++;
        total++;
        if (out_data !== prev_d || out_sat !== prev_s) begin
          bad++;
          $display("FAIL b2b_hold c%0d: got %h/%b want %h/%b",
                   cyc, out_data, out_sat, prev_d, prev_s);
        end
      end
      cons = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (cons) begin
        total++;
        if (rx >= 8) begin
          bad++;
          $display("FAIL b2b_extra: got %h want none", out_data);
        end else if (out_data !== exd[rx] || out_sat !== exs[rx]) begin
          bad++;
          $display("FAIL b2b_data%0d: got %h/%b want %h/%b",
                   rx, out_data, out_sat, exd[rx], exs[rx]);
        end
        rx++;
      end
      if (acc) tx++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_s = out_sat;
      if (s2a) m_out = m_s1;
      if (exp_rdy) m_s1 = acc;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rx != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 8 (cycles=%0d)", rx, cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_tail: out_valid=%b want 0", out_valid);
    end
    $display("back-to-back: %0d cycles, %0d stalled cycles", cyc, stalls);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0100;
    in_mode   = 2'b00;
    @(posedge clk); #1;
    in_data   = 16'h0200;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstm_full: v=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstm_async: v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstm_stale%0d: out_valid=%b data=%h want 0",
                 i, out_valid, out_data);
      end
    end
  endtask

`ifdef FIXED_ROUND_SAT_COUNT_EN
  task automatic test_sat_count();
    out_ready = 1'b1;
    sat_count_clr = 1'b1;
    @(posedge clk); #1;
    sat_count_clr = 1'b0;
    total++;
    if (sat_count !== 16'd0) begin
      bad++;
      $display("FAIL cnt_clr: got %0d want 0", sat_count);
    end
    in_valid = 1'b1;
    in_data  = 16'h7F80;
    in_mode  = 2'b01;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sat_count !== 16'd3) begin
      bad++;
      $display("FAIL cnt_three: got %0d want 3", sat_count);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1 || sat_count !== 16'd3) begin
      bad++;
      $display("FAIL cnt_stall: v=%b s=%b cnt=%0d want 1/1/3",
               out_valid, out_sat, sat_count);
    end
    out_ready = 1'b1;
    sat_count_clr = 1'b1;
    @(posedge clk); #1;
    sat_count_clr = 1'b0;
    total++;
    if (sat_count !== 16'd0) begin
      bad++;
      $display("FAIL cnt_clr_wins: got %0d want 0", sat_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rounding();
    test_out_w6();
    test_back_to_back();
    test_reset_midstream();
`ifdef FIXED_ROUND_SAT_COUNT_EN
    test_sat_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
